// File: rtl/push_conditioner.sv
// push_conditioner: per-button sync, debounce, press/repeat/release pulses
// for the front-panel buttons feeding the write and crono state machines.
module push_conditioner #(
    parameter int N_BTN = 5,
    parameter int DB_CYC = 1000000,
    parameter int REP_DLY = 50000000,
    parameter int REP_PER = 10000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK = 5'b01111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_pulse
);
    localparam int MX = (DB_CYC > REP_DLY) ? ((DB_CYC > REP_PER) ? DB_CYC : REP_PER)
                                           : ((REP_DLY > REP_PER) ? REP_DLY : REP_PER);
    localparam int CW = (MX > 1) ? $clog2(MX) : 1;
    localparam logic [CW-1:0] DB_T = CW'(DB_CYC - 1);
    localparam logic [CW-1:0] DLY_T = CW'(REP_DLY - 1);
    localparam logic [CW-1:0] PER_T = CW'(REP_PER - 1);

    typedef enum logic [1:0] {IDLE, HELD_DLY, HELD_REP} state_t;

    logic [N_BTN-1:0] s1, s2, pulse_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            any_pulse <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            any_pulse <= |pulse_nxt;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        state_t st;
        logic [CW-1:0] cnt, rc;
        logic lvl, pls, rel, flip, rise, fall, rep;

        always_comb begin
            flip = (s2[g] != lvl) && (cnt == DB_T);
            rise = flip && !lvl;
            fall = flip && lvl;
            rep = REPEAT_MASK[g] && ((st == HELD_DLY && rc == DLY_T) || (st == HELD_REP && rc == PER_T));
        end

        // a release always wins over a repeat that lands on the same edge
        assign pulse_nxt[g] = rise || (rep && !fall);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st <= IDLE;
                cnt <= '0;
                rc <= '0;
                lvl <= 1'b0;
                pls <= 1'b0;
                rel <= 1'b0;
            end else begin
                cnt <= (s2[g] == lvl || flip) ? '0 : cnt + 1'b1;
                lvl <= lvl ^ flip;
                pls <= pulse_nxt[g];
                rel <= fall;
                if (rise || fall) begin
                    st <= fall ? IDLE : HELD_DLY;
                    rc <= '0;
                end else if (st != IDLE && REPEAT_MASK[g]) begin
                    rc <= rep ? '0 : rc + 1'b1;
                    if (rep) st <= HELD_REP;
                end
            end
        end

        assign btn_level[g] = lvl;
        assign btn_pulse[g] = pls;
        assign btn_release[g] = rel;
    end
endmodule

// File: tb/tb_push_conditioner.sv
// tb_push_conditioner: directed and random button traffic checked against
// a history-based behavioural model of debounce, repeat and release.
module tb_push_conditioner;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam logic [4:0] MASK = 5'b01111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level, btn_pulse, btn_release;
    logic any_pulse;

    int vecs = 0;
    int errs = 0;

    push_conditioner #(.N_BTN(5), .DB_CYC(DB), .REP_DLY(RD), .REP_PER(RP), .REPEAT_MASK(MASK)) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .btn_release(btn_release),
        .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    // model state: raw samples per edge (newest first), level, hold time since press
    logic [4:0] hist[$];
    logic [4:0] m_lvl, e_pulse, e_rel;
    int hold[5];
    int cp[5], cr[5], cl[5];
    int ca;

    task automatic model_reset();
        hist = {};
        repeat (DB + 2) hist.push_front(5'b0);
        m_lvl = '0;
        e_pulse = '0;
        e_rel = '0;
        for (int b = 0; b < 5; b++) hold[b] = 0;
    endtask

    // level flips once the synchronised input has disagreed with it for DB straight edges
    task automatic model_edge(input logic [4:0] s);
        logic diff;
        hist.push_front(s);
        void'(hist.pop_back());
        for (int b = 0; b < 5; b++) begin
            diff = 1'b1;
            for (int j = 0; j < DB; j++)
                if (hist[2 + j][b] == m_lvl[b]) diff = 1'b0;
            if (diff && !m_lvl[b]) hold[b] = 0;
            else if (m_lvl[b]) hold[b]++;
            e_pulse[b] = (diff && !m_lvl[b]) ||
                         (m_lvl[b] && !diff && MASK[b] && hold[b] >= RD && (hold[b] - RD) % RP == 0);
            e_rel[b] = diff && m_lvl[b];
            m_lvl[b] = m_lvl[b] ^ diff;
        end
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("level", btn_level, m_lvl);
        chk("pulse", btn_pulse, e_pulse);
        chk("release", btn_release, e_rel);
        chk("any_pulse", {4'b0, any_pulse}, {4'b0, |e_pulse});
    endtask

    task automatic tick();
        logic [4:0] s;
        @(posedge clk);
        s = btn_raw;
        if (rst) model_reset();
        else model_edge(s);
        #1;
        check_all();
        for (int b = 0; b < 5; b++) begin
            cp[b] += int'(btn_pulse[b]);
            cr[b] += int'(btn_release[b]);
            cl[b] += int'(btn_level[b]);
        end
        ca += int'(any_pulse);
    endtask

    task automatic clear_counts();
        for (int b = 0; b < 5; b++) begin
            cp[b] = 0;
            cr[b] = 0;
            cl[b] = 0;
        end
        ca = 0;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        logic [4:0] bounce;
        model_reset();
        clear_counts();
        #2;
        check_all();
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // clean press on arriba
        clear_counts();
        btn_raw[2] = 1'b1;
        repeat (10) tick();
        btn_raw[2] = 1'b0;
        repeat (8) tick();
        chk_int("arriba_pulses", cp[2], 1);
        chk_int("arriba_releases", cr[2], 1);
        chk_int("arriba_level_cycles", cl[2], 10);

        // bounce shorter than the debounce window on abajo
        clear_counts();
        bounce = 5'b10110;
        for (int i = 4; i >= 0; i--) begin
            btn_raw[3] = bounce[i];
            tick();
        end
        btn_raw[3] = 1'b0;
        repeat (8) tick();
        chk_int("bounce_pulses", cp[3], 0);
        chk_int("bounce_releases", cr[3], 0);
        chk_int("bounce_level_cycles", cl[3], 0);

        // izquierda held: press, repeats at 20,28,36,44,52, release cancels the one at 60
        clear_counts();
        btn_raw[0] = 1'b1;
        repeat (60) tick();
        btn_raw[0] = 1'b0;
        repeat (8) tick();
        chk_int("izq_hold_pulses", cp[0], 6);
        chk_int("izq_hold_releases", cr[0], 1);

        // centro never repeats
        clear_counts();
        btn_raw[4] = 1'b1;
        repeat (70) tick();
        btn_raw[4] = 1'b0;
        repeat (8) tick();
        chk_int("centro_pulses", cp[4], 1);
        chk_int("centro_releases", cr[4], 1);

        // derecha and abajo on the same edge
        clear_counts();
        btn_raw = 5'b01010;
        repeat (10) tick();
        btn_raw = '0;
        repeat (8) tick();
        chk_int("der_pulses", cp[1], 1);
        chk_int("abajo_pulses", cp[3], 1);
        chk_int("simul_any_cycles", ca, 1);

        // reset in the middle of an izquierda hold
        clear_counts();
        btn_raw[0] = 1'b1;
        repeat (31) tick();
        async_reset();
        repeat (2) tick();
        rst = 1'b0;
        clear_counts();
        repeat (26) tick();
        chk_int("post_reset_pulses", cp[0], 2);
        btn_raw[0] = 1'b0;
        repeat (8) tick();

        // random traffic with occasional mid-cycle resets
        repeat (150) begin
            btn_raw = 5'($urandom);
            repeat ($urandom_range(1, 25)) tick();
            if ($urandom_range(0, 19) == 0) begin
                async_reset();
                tick();
                rst = 1'b0;
            end
        end
        btn_raw = '0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/push_conditioner.md
Name: push_conditioner

Overview:
- Conditions the five front-panel push buttons (izquierda, derecha, arriba, abajo, centro) before they reach the write state machine and the chronometer state machine.
- Per button, it does three things:
  - synchronises the raw pad input to clk;
  - debounces it;
  - produces a debounced level, a one-cycle press pulse with optional hold-to-repeat, and a one-cycle release pulse.
- Sits between the board pins and the time-setting / crono-programming logic. Downstream logic may treat every pulse as exactly one increment or one cursor move.

Parameters:
- N_BTN, 5, number of buttons. Bit order: 0 izquierda, 1 derecha, 2 arriba, 3 abajo, 4 centro.
- DB_CYC, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- REP_DLY, 50000000, cycles from the initial press pulse to the first repeat pulse (500 ms).
- REP_PER, 10000000, cycles between subsequent repeat pulses (100 ms).
- REPEAT_MASK, 5'b01111, per-button repeat enable. centro never repeats because it starts/stops the crono.

Ports:
- clk  input  1  system clock, 100 MHz.
- Reset  input  1  asynchronous, active-high reset; clears all state.
- btn_raw  input  N_BTN  raw, asynchronous pad inputs, active-high.
- btn_level  output  N_BTN  debounced level.
- btn_pulse  output  N_BTN  one-cycle pulse on accepted press and on each repeat.
- btn_release  output  N_BTN  one-cycle pulse on accepted release.
- any_pulse  output  1  OR of btn_pulse, registered in the same cycle as btn_pulse.

Behaviour:
- Reset (asynchronous, active-high): synchroniser flops, btn_level, btn_pulse, btn_release, any_pulse, all debounce counters and all repeat counters go to 0. Every FSM goes to IDLE.
- Synchroniser: two flops per button, s1 then s2. Only s2 is used downstream.
- Debounce, per button:
  - cnt increments on every edge where s2 != btn_level.
  - cnt clears to 0 on any edge where s2 == btn_level.
  - On the edge where cnt would reach DB_CYC, btn_level toggles and cnt clears.
  - Glitches shorter than DB_CYC cycles never reach btn_level.
- Latency: let edge 0 be the first clk edge that samples btn_raw=1 after a stable low. btn_level goes to 1 after edge DB_CYC+1, with raw held high throughout. Release has identical latency.
- Per-button FSM, states IDLE, HELD_DLY, HELD_REP:
  - IDLE → HELD_DLY on the edge that sets btn_level=1. btn_pulse=1 for exactly that one cycle. Repeat counter rc := 0.
  - HELD_DLY:
    - rc increments each cycle.
    - If REPEAT_MASK bit is 1 and rc == REP_DLY-1: btn_pulse=1 for one cycle, rc := 0, go to HELD_REP.
    - If REPEAT_MASK bit is 0: rc stays frozen at 0 and the FSM remains in HELD_DLY.
  - HELD_REP: rc increments. When rc == REP_PER-1: btn_pulse=1 for one cycle, rc := 0.
  - Any state → IDLE on the edge that clears btn_level. btn_release=1 for that one cycle. rc := 0. No btn_pulse is issued in that cycle, even if a repeat would have fired.
- Pulse timing:
  - btn_pulse and btn_release are registered.
  - They are asserted in the same cycle btn_level changes.
  - They are never high in two consecutive cycles for the same button, given REP_PER >= 2.
- Buttons are fully independent. Simultaneous presses produce simultaneous pulses on their respective bits. any_pulse is high if any bit of btn_pulse is high.
- Reset asserted mid-hold or mid-debounce: outputs are cleared immediately. After Reset deasserts with the button still held, a fresh DB_CYC+1 latency applies before a new press pulse.
- Counter widths: clog2 of the largest of DB_CYC, REP_DLY, REP_PER. No wrap is possible because each counter clears at its terminal count.
- No combinational path from btn_raw to any output.

Test Plan (params DB_CYC=4, REP_DLY=20, REP_PER=8):
- Clean press on bit 2 (arriba), held 10 cycles then released:
  - btn_level[2] rises after edge 5;
  - btn_pulse[2] is one cycle at the rise;
  - btn_release[2] is one cycle 5 edges after raw falls;
  - no repeat pulse.
- Bounce: raw toggles 1,0,1,1,0, then stays 0 → btn_level, btn_pulse and btn_release stay 0 throughout.
- Hold bit 0 (izquierda) for 60 cycles after level rise → pulses at t=0, 20, 28, 36, 44, 52 relative to the first pulse, then one release pulse.
- Hold bit 4 (centro) for 60 cycles → exactly one btn_pulse[4], no repeats, one btn_release[4].
- Press bits 1 and 3 on the same edge → btn_pulse=5'b01010 in one cycle, any_pulse=1 in that same cycle.
- Assert Reset at cycle 25 of a bit-0 hold, deassert with raw still high:
  - all outputs 0 immediately;
  - new btn_pulse[0] 5 edges after Reset release;
  - first repeat 20 cycles after that new pulse.
